sm_muldiv: RTL and testbench
============================

SM_MULDIV -- requirements
Module: sm_muldiv

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, as the operand width, limited to even values of 4 or more.
REQ-002 clk  input  1  Clock; all state changes on the rising edge.
REQ-003 rst  input  1  Reset, asynchronous and active-high.
REQ-004 start  input  1  Operation request; sampled only while busy=0.
REQ-005 op  input  2  Operation: 00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
REQ-006 srcA  input  WIDTH  Multiplicand or dividend.
REQ-007 srcB  input  WIDTH  Multiplier or divisor.
REQ-008 busy  output  1  High while an operation is in progress.
REQ-009 done  output  1  One-cycle pulse marking a new result on hi/lo.
REQ-010 hi  output  WIDTH  Product upper half, or remainder.
REQ-011 lo  output  WIDTH  Product lower half, or quotient.
REQ-012 divZero  output  1  Set when the last completed divide had srcB=0.

Function
REQ-013 The FSM SHALL have the states IDLE, CALC and FIXUP, and SHALL be in IDLE out of reset.
REQ-014 In IDLE with start=1, the block SHALL latch op, srcA and srcB, compute the operand magnitudes for signed ops, set busy and enter CALC at that edge.
REQ-015 CALC SHALL run exactly WIDTH cycles of radix-2 shift-add (multiply) or restoring shift-subtract (divide), counted by an internal counter that wraps WIDTH-1 -> 0 as the FSM moves to FIXUP.
REQ-016 FIXUP SHALL apply sign correction for one cycle, then at its closing edge load hi/lo, update divZero, set done, clear busy and return to IDLE.
REQ-017 Latency SHALL be fixed at WIDTH+2 cycles: start sampled at edge 0 gives done=1 after edge WIDTH+2, with no dependence on operands.
REQ-018 done SHALL be high for exactly one cycle, and hi/lo/divZero SHALL hold their values until the next completion or reset.
REQ-019 A start asserted while busy=1 SHALL be ignored without any effect on state or outputs.
REQ-020 A start asserted in the cycle where done=1 SHALL be accepted, because busy is already 0 in that cycle.
REQ-021 MULTU/MULT SHALL produce the full 2*WIDTH-bit product in {hi,lo}, unsigned or two's-complement signed as selected.
REQ-022 DIVU/DIV SHALL put the quotient in lo and the remainder in hi.
REQ-023 Signed division SHALL truncate the quotient toward zero and give the remainder the sign of the dividend.
REQ-024 Divide by zero (srcB=0) SHALL give lo = all ones, hi = srcA unchanged and divZero=1, with the normal latency.
REQ-025 A completed multiply, or a divide with srcB!=0, SHALL clear divZero.
REQ-026 Signed overflow (DIV of the most negative value by -1) SHALL give lo = most negative value, hi = 0 and divZero=0.
REQ-027 No internal arithmetic SHALL overflow: accumulators are 2*WIDTH bits and the partial remainder is WIDTH+1 bits.

Reset
REQ-028 Asserting rst SHALL immediately force state IDLE, busy=0, done=0, hi=0, lo=0, divZero=0 and counter=0, whatever the clock is doing.
REQ-029 An rst asserted during CALC or FIXUP SHALL abort the operation, with no done pulse at any later time.
REQ-030 After rst is released, the first rising edge with start=1 SHALL begin a new operation normally.

Verification (WIDTH=32 unless stated)
REQ-031 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high edges 1..34; done high after edge 34 only.
REQ-032 MULT 0xFFFFFFFD (-3) x 0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064, divZero=1; following DIVU 100/7 -> lo=14, hi=2, divZero=0.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, divZero=0.
REQ-035 start pulses held during busy are ignored (exactly one done per accepted start); back-to-back start on the done cycle gives a second done exactly 34 cycles later.
REQ-036 rst pulsed at cycle 10 of a MULTU -> busy, done, hi, lo all 0 at once, with no later done; repeat REQ-031/032 at WIDTH=8 (0xFF x 0xFF -> hi=0xFE, lo=0x01, latency 10).

Source files
------------

// File: rtl/sm_muldiv.sv
// sm_muldiv: iterative multiply/divide unit, fixed WIDTH+2 cycle latency.
// Ports: clk, rst (async, high), start, op[1:0], srcA, srcB -> busy, done, hi, lo, divZero.
//   op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV. Mul: {hi,lo}=product. Div: lo=quot, hi=rem.
module sm_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divZero
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  generate
    if ((WIDTH < 4) || (WIDTH % 2 != 0)) begin : g_bad_width
      $error("sm_muldiv: WIDTH must be even and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic              fix_q;
  logic              isdiv_q;
  logic              zero_q;
  logic              negq_q;
  logic              negr_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  amag_q;
  logic [WIDTH-1:0]  bmag_q;
  // Mul: running {partial product, multiplier}. Div: quotient in low half.
  logic [W2-1:0]     acc_q;
  logic [WIDTH-1:0]  rem_q;
  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  hi_q;
  logic [WIDTH-1:0]  lo_q;
  logic              dz_q;

  logic              sgn_a;
  logic              sgn_b;
  logic [WIDTH-1:0]  amag_d;
  logic [WIDTH-1:0]  bmag_d;
  logic [WIDTH:0]    mul_sum;
  logic [W2-1:0]     mul_d;
  logic [WIDTH:0]    div_sh;
  logic [WIDTH:0]    div_diff;
  logic [WIDTH-1:0]  rem_d;
  logic [WIDTH-1:0]  quo_d;
  logic [WIDTH-1:0]  qv;
  logic [WIDTH-1:0]  rv;
  logic [W2-1:0]     fix_d;

  always_comb begin
    sgn_a  = op[0] & srcA[WIDTH-1];
    sgn_b  = op[0] & srcB[WIDTH-1];
    amag_d = sgn_a ? -srcA : srcA;
    bmag_d = sgn_b ? -srcB : srcB;

    // One shift-add step; the carry lands in the top bit.
    mul_sum = {1'b0, acc_q[W2-1:WIDTH]};
    if (acc_q[0]) begin
      mul_sum = mul_sum + {1'b0, amag_q};
    end
    mul_d = {mul_sum, acc_q[WIDTH-1:1]};

    // One restoring step; a negative trial keeps the shifted value.
    div_sh   = {rem_q, acc_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, bmag_q};
    if (!div_diff[WIDTH]) begin
      rem_d = div_diff[WIDTH-1:0];
      quo_d = {acc_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = div_sh[WIDTH-1:0];
      quo_d = {acc_q[WIDTH-2:0], 1'b0};
    end

    qv = negq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rv = negr_q ? -rem_q : rem_q;
    if (!isdiv_q) begin
      fix_d = negq_q ? -acc_q : acc_q;
    end else if (zero_q) begin
      // Divide by zero passes the dividend through untouched.
      fix_d = {a_q, {WIDTH{1'b1}}};
    end else begin
      fix_d = {rv, qv};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fix_q   <= 1'b0;
      isdiv_q <= 1'b0;
      zero_q  <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      a_q     <= '0;
      amag_q  <= '0;
      bmag_q  <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= CALC;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            fix_q   <= 1'b0;
            isdiv_q <= op[1];
            zero_q  <= op[1] & (srcB == '0);
            negq_q  <= sgn_a ^ sgn_b;
            negr_q  <= sgn_a;
            a_q     <= srcA;
            amag_q  <= amag_d;
            bmag_q  <= bmag_d;
            rem_q   <= '0;
            acc_q   <= op[1] ? {{WIDTH{1'b0}}, amag_d}
                             : {{WIDTH{1'b0}}, bmag_d};
          end
        end
        CALC: begin
          if (isdiv_q) begin
            acc_q <= {acc_q[W2-1:WIDTH], quo_d};
            rem_q <= rem_d;
          end else begin
            acc_q <= mul_d;
          end
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_q   <= '0;
            state_q <= FIXUP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        FIXUP: begin
          if (!fix_q) begin
            acc_q <= fix_d;
            fix_q <= 1'b1;
          end else begin
            hi_q    <= acc_q[W2-1:WIDTH];
            lo_q    <= acc_q[WIDTH-1:0];
            dz_q    <= zero_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            fix_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign divZero = dz_q;

endmodule

// File: tb/tb_sm_muldiv.sv
// tb_sm_muldiv: scoreboard bench for sm_muldiv at WIDTH=32 and WIDTH=8.
// Expected results come from a plain-arithmetic reference model.
module tb_sm_muldiv;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        st32, st8;
  logic [1:0]  op32, op8;
  logic [31:0] a32, b32, hi32, lo32;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy32, done32, dz32;
  logic        busy8, done8, dz8;

  sm_muldiv #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .start(st32), .op(op32),
    .srcA(a32), .srcB(b32), .busy(busy32), .done(done32),
    .hi(hi32), .lo(lo32), .divZero(dz32)
  );

  sm_muldiv #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(st8), .op(op8),
    .srcA(a8), .srcB(b8), .busy(busy8), .done(done8),
    .hi(hi8), .lo(lo8), .divZero(dz8)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int checks = 0;
  int errors = 0;
  int ndone32 = 0;
  int ndone8 = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: signed math on 64-bit integers, then cut to w bits.
  function automatic exp_t model(input logic [1:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b, input int w);
    exp_t e;
    logic [63:0] mask, ua, ub, p, q, r;
    longint sa, sb;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    e.dz = 1'b0;
    p = '0;
    q = '0;
    r = '0;
    case (op)
      2'b00: p = ua * ub;
      2'b01: p = 64'(sa * sb);
      2'b10: if (ub != 0) begin q = ua / ub; r = ua % ub; end
      default: if (ub != 0) begin
        q = 64'(sa / sb);
        r = 64'(sa % sb);
      end
    endcase
    if (!op[1]) begin
      e.hi = 32'((p >> w) & mask);
      e.lo = 32'(p & mask);
    end else if (ub == 0) begin
      e.hi = 32'(ua);
      e.lo = 32'(mask);
      e.dz = 1'b1;
    end else begin
      e.hi = 32'(r & mask);
      e.lo = 32'(q & mask);
    end
    return e;
  endfunction

  function automatic logic bsy(input int w);
    return (w == 32) ? busy32 : busy8;
  endfunction

  function automatic logic dn(input int w);
    return (w == 32) ? done32 : done8;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done32 === 1'b1) begin
      ndone32++;
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u32 stray done actual=%h_%h required=none",
                 hi32, lo32);
      end else begin
        e = q32.pop_front();
        chk("u32 hi", hi32, e.hi);
        chk("u32 lo", lo32, e.lo);
        chk("u32 divZero", dz32, e.dz);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done8 === 1'b1) begin
      ndone8++;
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u8 stray done actual=%h_%h required=none",
                 hi8, lo8);
      end else begin
        e = q8.pop_front();
        chk("u8 hi", hi8, e.hi);
        chk("u8 lo", lo8, e.lo);
        chk("u8 divZero", dz8, e.dz);
      end
    end
  end

  task automatic wait_idle(input int w);
    int n = 0;
    while (bsy(w) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("wait idle timeout", n, 0);
  endtask

  task automatic drive(input int w, input logic s, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (w == 32) begin
      st32 = s; op32 = op; a32 = a; b32 = b;
    end else begin
      st8 = s; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input int w, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    wait_idle(w);
    drive(w, 1'b1, op, a, b);
    if (w == 32) q32.push_back(model(op, a, b, 32));
    else q8.push_back(model(op, a, b, 8));
    @(negedge clk);
    drive(w, 1'b0, op, a, b);
  endtask

  task automatic drain(input int w);
    int n = 0;
    while (((w == 32) ? q32.size() : q8.size()) > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain timeout", n, 0);
  endtask

  task automatic lat(input int w, input logic [1:0] op,
                     input logic [31:0] a, input logic [31:0] b);
    int bad = 0;
    int dpos = -1;
    issue(w, op, a, b);
    for (int k = 1; k <= w + 3; k++) begin
      @(posedge clk);
      #1;
      if (k <= w + 1 && (!bsy(w) || dn(w))) bad++;
      if (k >= w + 2 && bsy(w)) bad++;
      if (dn(w)) begin
        if (dpos < 0) dpos = k;
        else bad++;
      end
    end
    chk($sformatf("w%0d busy/done profile", w), bad, 0);
    chk($sformatf("w%0d done edge", w), dpos, w + 2);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd(input int w);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return m;
      3: return 32'd1 << (w - 1);
      default: return $urandom & m;
    endcase
  endfunction

  initial begin
    int nd, n;
    rst = 1'b1;
    drive(32, 1'b0, 2'b00, 32'd0, 32'd0);
    drive(8, 1'b0, 2'b00, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("reset u32", {busy32, done32, dz32, hi32, lo32}, 0);
    chk("reset u8", {busy8, done8, dz8, hi8, lo8}, 0);
    rst = 1'b0;
    @(negedge clk);

    lat(32, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu max", {hi32, lo32}, 64'hFFFF_FFFE_0000_0001);

    issue(32, 2'b01, 32'hFFFF_FFFD, 32'h5);
    drain(32);
    chk("mult -3*5", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFF1);
    issue(32, 2'b11, 32'hFFFF_FFF9, 32'h2);
    drain(32);
    chk("div -7/2", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFFD);

    issue(32, 2'b10, 32'd100, 32'd0);
    drain(32);
    chk("divu by 0", {dz32, hi32, lo32}, {31'd0, 1'b1, 32'd100, 32'hFFFF_FFFF});
    issue(32, 2'b10, 32'd100, 32'd7);
    drain(32);
    chk("divu 100/7", {dz32, hi32, lo32}, {31'd0, 1'b0, 32'd2, 32'd14});

    issue(32, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    drain(32);
    repeat (5) @(negedge clk);
    chk("div ovf held", {dz32, hi32, lo32}, {32'd0, 32'd0, 32'h8000_0000});

    nd = ndone32;
    issue(32, 2'b00, 32'd12345, 32'd678);
    for (int i = 0; i < 20; i++) begin
      drive(32, 1'b1, 2'($urandom), $urandom, $urandom);
      @(negedge clk);
    end
    drive(32, 1'b0, 2'b00, 32'd0, 32'd0);
    drain(32);
    repeat (40) @(negedge clk);
    chk("starts ignored while busy", ndone32 - nd, 1);

    issue(32, 2'b01, 32'hDEAD_BEEF, 32'h1234_5678);
    n = 0;
    while (!done32 && n < 100) begin
      @(negedge clk);
      n++;
    end
    drive(32, 1'b1, 2'b10, 32'hCAFE_F00D, 32'd33);
    q32.push_back(model(2'b10, 32'hCAFE_F00D, 32'd33, 32));
    @(negedge clk);
    drive(32, 1'b0, 2'b00, 32'd0, 32'd0);
    n = 1;
    while (!done32 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("back-to-back latency", n - 1, 34);
    drain(32);

    issue(32, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async reset mid-calc", {busy32, done32, dz32, hi32, lo32}, 0);
    q32.delete();
    nd = ndone32;
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("no done after abort", ndone32 - nd, 0);
    issue(32, 2'b00, 32'd6, 32'd7);
    drain(32);
    chk("op after reset", {hi32, lo32}, 64'd42);

    for (int i = 0; i < 40; i++) begin
      issue(32, 2'($urandom), rnd(32), rnd(32));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 5)) @(negedge clk);
    end
    drain(32);

    lat(8, 2'b00, 32'hFF, 32'hFF);
    chk("w8 multu max", {hi8, lo8}, 16'hFE01);
    issue(8, 2'b01, 32'hFD, 32'h05);
    drain(8);
    chk("w8 mult -3*5", {hi8, lo8}, 16'hFFF1);
    issue(8, 2'b11, 32'hF9, 32'h02);
    drain(8);
    chk("w8 div -7/2", {hi8, lo8}, 16'hFFFD);
    issue(8, 2'b11, 32'h80, 32'hFF);
    drain(8);
    chk("w8 div ovf", {dz8, hi8, lo8}, {8'd0, 1'b0, 8'h00, 8'h80});
    for (int i = 0; i < 60; i++) issue(8, 2'($urandom), rnd(8), rnd(8));
    drain(8);

    repeat (5) @(negedge clk);
    chk("scoreboards empty", q32.size() + q8.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
